// File: rtl/mem_access_stage.sv
// MEM stage of the pipelined ARMv8 core.
// Resolves the conditional branch, runs a req/ack handshake to data memory,
// loads the MEM/WB pipeline register and stalls upstream while memory is busy.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   ex_*                       EX/MEM results and control from the execution stage
//   dmem_req/we/addr/wdata     registered request to data memory, held until ack
//   dmem_ack/rdata             memory completion and load data
//   stall                      combinational freeze of PC, IF/ID, ID/EX, EX/MEM
//   pc_src, branch_target      combinational branch resolution
//   wb_*                       MEM/WB pipeline register
module mem_access_stage #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_write_data,
  input  logic              ex_zero,
  input  logic [DATA_W-1:0] ex_branch_target,
  input  logic              ex_branch,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  input  logic [REG_W-1:0]  ex_rd,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall,
  output logic              pc_src,
  output logic [DATA_W-1:0] branch_target,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [DATA_W-1:0] wb_read_data
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                memop;
  logic                req_d;
  logic                we_d;
  logic [DATA_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d;
  logic                wb_load;
  logic                wb_valid_d;
  logic [DATA_W-1:0]   wb_read_data_d;

  // Load and store both set is illegal; ex_mem_write wins so it issues as a store.
  assign memop         = ex_valid & (ex_mem_read | ex_mem_write);
  assign pc_src        = ex_valid & ex_branch & ex_zero & (state_q == IDLE);
  assign branch_target = ex_branch_target;

  // Next-state, request and MEM/WB load decisions.
  always_comb begin
    state_d        = state_q;
    req_d          = dmem_req;
    we_d           = dmem_we;
    addr_d         = dmem_addr;
    wdata_d        = dmem_wdata;
    wb_load        = 1'b0;
    wb_valid_d     = 1'b0;
    wb_read_data_d = wb_read_data;
    stall          = 1'b0;
    case (state_q)
      IDLE: begin
        if (memop) begin
          // Launch the request; a bubble enters WB while memory works.
          req_d   = 1'b1;
          we_d    = ex_mem_write;
          addr_d  = ex_alu_result;
          wdata_d = ex_write_data;
          stall   = 1'b1;
          state_d = ACCESS;
        end else begin
          wb_load        = 1'b1;
          wb_valid_d     = ex_valid;
          wb_read_data_d = '0;
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          wb_load        = 1'b1;
          wb_valid_d     = 1'b1;
          wb_read_data_d = dmem_we ? '0 : dmem_rdata;
          req_d          = 1'b0;
          we_d           = 1'b0;
          state_d        = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, memory request and MEM/WB registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_rd         <= '0;
      wb_alu_result <= '0;
      wb_read_data  <= '0;
    end else begin
      state_q      <= state_d;
      dmem_req     <= req_d;
      dmem_we      <= we_d;
      dmem_addr    <= addr_d;
      dmem_wdata   <= wdata_d;
      wb_valid     <= wb_valid_d;
      wb_read_data <= wb_read_data_d;
      if (wb_load) begin
        wb_reg_write  <= ex_reg_write;
        wb_mem_to_reg <= ex_mem_to_reg;
        wb_rd         <= ex_rd;
        wb_alu_result <= ex_alu_result;
      end
    end
  end

endmodule
